// File: rtl/sw_debounce_capture_pkg.sv
// rtl/sw_debounce_capture_pkg.sv - board defaults for the switch debounce/capture path
package sw_debounce_capture_pkg;

  localparam int DEFAULT_WIDTH         = 12;
  localparam int DEFAULT_STABLE_CYCLES = 16;

endpackage

// File: rtl/sw_debounce_capture_bit_sync2.sv
// rtl/sw_debounce_capture_bit_sync2.sv - two-flop synchroniser, vectorised, async reset to 0
module bit_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/sw_debounce_capture.sv
// rtl/sw_debounce_capture.sv - synchronise and debounce the SW bus as one word,
// deliver each new stable word as a valid/ready transaction
module sw_debounce_capture
  import sw_debounce_capture_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DATA,
  output logic [WIDTH-1:0] SW_CHANGED,
  output logic             SW_OVERRUN,
  output logic             SW_VALID,
  input  logic             SW_READY
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] stable;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             commit;
  logic [WIDTH-1:0] diff;

  bit_sync2 #(.WIDTH(WIDTH)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (SW),
    .q     (s2)
  );

  // Commit once the candidate has held for the full window and differs from
  // the last committed word; the saturated counter keeps it from repeating.
  assign sat    = (cnt == CNT_LAST);
  assign commit = (s2 == cand) && sat && (cand != stable);
  assign diff   = cand ^ stable;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cand       <= '0;
      stable     <= '0;
      cnt        <= '0;
      SW_DATA    <= '0;
      SW_CHANGED <= '0;
      SW_OVERRUN <= 1'b0;
      SW_VALID   <= 1'b0;
    end else begin
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else if (!sat) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (commit) begin
        stable <= cand;
      end

      // A commit overwrites an unaccepted word and accumulates its change mask.
      if (commit && (!SW_VALID || SW_READY)) begin
        SW_DATA    <= cand;
        SW_CHANGED <= diff;
        SW_OVERRUN <= 1'b0;
        SW_VALID   <= 1'b1;
      end else if (commit) begin
        SW_DATA    <= cand;
        SW_CHANGED <= SW_CHANGED | diff;
        SW_OVERRUN <= 1'b1;
      end else if (SW_VALID && SW_READY) begin
        SW_VALID   <= 1'b0;
        SW_CHANGED <= '0;
        SW_OVERRUN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce_capture.sv
// tb/tb_sw_debounce_capture.sv - directed and randomized checks of sw_debounce_capture
// against a sample-history reference model
module tb_sw_debounce_capture;

  localparam int W  = 12;
  localparam int SC = 16;
  localparam int HL = SC + 3;

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] SW;
  logic [W-1:0] SW_DATA;
  logic [W-1:0] SW_CHANGED;
  logic         SW_OVERRUN;
  logic         SW_VALID;
  logic         SW_READY;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hq [$];
  logic [W-1:0] m_stable, m_data, m_changed;
  logic         m_over, m_valid;

  sw_debounce_capture #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .SW         (SW),
    .SW_DATA    (SW_DATA),
    .SW_CHANGED (SW_CHANGED),
    .SW_OVERRUN (SW_OVERRUN),
    .SW_VALID   (SW_VALID),
    .SW_READY   (SW_READY)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic model_reset();
    hq.delete();
    m_stable = '0; m_data = '0; m_changed = '0; m_over = 1'b0; m_valid = 1'b0;
  endtask

  // A word commits when the SC+1 samples taken two edges and more ago all agree
  // and differ from the last committed word; samples before reset count as 0.
  task automatic model_edge(input logic [W-1:0] sw, input logic rdy);
    logic [W-1:0] w [HL];
    int pad;
    bit eq, commit;
    logic [W-1:0] diff;
    hq.push_back(sw);
    if (hq.size() > HL) void'(hq.pop_front());
    pad = HL - hq.size();
    for (int i = 0; i < HL; i++) begin
      if (i < pad) w[i] = '0;
      else w[i] = hq[i - pad];
    end
    eq = 1'b1;
    for (int i = 1; i <= SC; i++) if (w[i] !== w[0]) eq = 1'b0;
    commit = eq && (w[0] !== m_stable);
    diff = w[0] ^ m_stable;
    if (commit && (!m_valid || rdy)) begin
      m_data = w[0]; m_changed = diff; m_over = 1'b0; m_valid = 1'b1;
    end else if (commit) begin
      m_data = w[0]; m_changed = m_changed | diff; m_over = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0; m_changed = '0; m_over = 1'b0;
    end
    if (commit) m_stable = w[0];
  endtask

  task automatic check_model(input string tag);
    checks += 4;
    assert (SW_DATA === m_data) else begin
      errors++; $error("FAIL %s data obs=%h exp=%h", tag, SW_DATA, m_data);
    end
    assert (SW_CHANGED === m_changed) else begin
      errors++; $error("FAIL %s changed obs=%h exp=%h", tag, SW_CHANGED, m_changed);
    end
    assert (SW_OVERRUN === m_over) else begin
      errors++; $error("FAIL %s overrun obs=%b exp=%b", tag, SW_OVERRUN, m_over);
    end
    assert (SW_VALID === m_valid) else begin
      errors++; $error("FAIL %s valid obs=%b exp=%b", tag, SW_VALID, m_valid);
    end
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] d, input logic [W-1:0] c,
                            input logic o, input logic v);
    checks += 4;
    assert (SW_DATA === d) else begin
      errors++; $error("FAIL %s data obs=%h exp=%h", tag, SW_DATA, d);
    end
    assert (SW_CHANGED === c) else begin
      errors++; $error("FAIL %s changed obs=%h exp=%h", tag, SW_CHANGED, c);
    end
    assert (SW_OVERRUN === o) else begin
      errors++; $error("FAIL %s overrun obs=%b exp=%b", tag, SW_OVERRUN, o);
    end
    assert (SW_VALID === v) else begin
      errors++; $error("FAIL %s valid obs=%b exp=%b", tag, SW_VALID, v);
    end
  endtask

  task automatic step(input logic [W-1:0] sw, input logic rdy, input string tag);
    @(negedge CLK);
    SW = sw;
    SW_READY = rdy;
    @(posedge CLK);
    model_edge(sw, rdy);
    #1 check_model(tag);
  endtask

  task automatic hold(input logic [W-1:0] sw, input logic rdy, input int n, input string tag);
    repeat (n) step(sw, rdy, tag);
  endtask

  // Reset is asserted between edges so the clear must be asynchronous.
  task automatic async_reset(input string tag);
    #2 RST_N = 1'b0;
    #1 model_reset();
    expect_out(tag, '0, '0, 1'b0, 1'b0);
    #2 RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; SW = '0; SW_READY = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 expect_out("reset", '0, '0, 1'b0, 1'b0);
    #2 RST_N = 1'b1;

    hold(12'h000, 1'b1, 100, "idle_zero");
    expect_out("idle_zero_end", '0, '0, 1'b0, 1'b0);

    hold(12'h111, 1'b1, 18, "first_pre");
    expect_out("first_e18", '0, '0, 1'b0, 1'b0);
    step(12'h111, 1'b1, "first_e19");
    expect_out("first_e19", 12'h111, 12'h111, 1'b0, 1'b1);
    step(12'h111, 1'b1, "first_e20");
    expect_out("first_accept", 12'h111, '0, 1'b0, 1'b0);
    hold(12'h111, 1'b1, 10, "first_tail");

    hold(12'h222, 1'b1, 10, "glitch");
    hold(12'h111, 1'b1, 30, "glitch_back");
    expect_out("glitch_none", 12'h111, '0, 1'b0, 1'b0);
    hold(12'h222, 1'b0, 25, "hold222");
    expect_out("hold222", 12'h222, 12'h333, 1'b0, 1'b1);
    step(12'h222, 1'b1, "accept222");
    expect_out("accept222", 12'h222, '0, 1'b0, 1'b0);

    hold(12'h000, 1'b0, 30, "ovr_000");
    hold(12'h333, 1'b0, 30, "ovr_333");
    hold(12'h444, 1'b0, 30, "ovr_444");
    expect_out("overrun", 12'h444, 12'h777, 1'b1, 1'b1);
    step(12'h444, 1'b1, "overrun_accept");
    expect_out("overrun_accept", 12'h444, '0, 1'b0, 1'b0);

    hold(12'h000, 1'b1, 30, "pre_000");
    hold(12'h444, 1'b0, 30, "pend_444");
    expect_out("pend_444", 12'h444, 12'h444, 1'b0, 1'b1);
    hold(12'h555, 1'b0, 18, "same_edge_pre");
    step(12'h555, 1'b1, "same_edge");
    expect_out("same_edge", 12'h555, 12'h111, 1'b0, 1'b1);
    hold(12'h555, 1'b1, 3, "drain");

    hold(12'h777, 1'b1, 8, "midcount");
    async_reset("rst_midcount");
    hold(12'h123, 1'b0, 25, "pend_123");
    expect_out("pend_123", 12'h123, 12'h123, 1'b0, 1'b1);
    async_reset("rst_valid");
    hold(12'hFFF, 1'b0, 18, "fff_pre");
    expect_out("fff_e18", '0, '0, 1'b0, 1'b0);
    step(12'hFFF, 1'b0, "fff_e19");
    expect_out("fff_e19", 12'hFFF, 12'hFFF, 1'b0, 1'b1);

    for (int seg = 0; seg < 60; seg++) begin
      logic [W-1:0] v;
      int len;
      v = W'($urandom_range(0, 7) * 12'h249);
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++) step(v, ($urandom_range(0, 3) != 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
